// File: rtl/shift_add_multiplier_if.sv
// Handshake and operand bus between a multiply requester and shift_add_multiplier.
// Latency: none (wires only).
// Backpressure: requester may only expect acceptance of start while ready is high.
//
// Ports (signals):
//   start   requester -> multiplier   request a multiply
//   a, b    requester -> multiplier   unsigned multiplicand / multiplier
//   ready   multiplier -> requester   idle, start will be sampled
//   done    multiplier -> requester   one-cycle pulse, product updated
//   product multiplier -> requester   2*WIDTH-bit result of the last multiply
interface shift_add_multiplier_if #(
    parameter int WIDTH = 5
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 ready;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  ready, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, done, product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Latency: done is visible N edges after acceptance; N=WIDTH, or with
//          SHIFT_ADD_MUL_EARLY_EXIT_EN defined, N=max(1, bit length of b).
// Backpressure: ready is low in RUN and DONE; start raised then is dropped.
//
// Ports: clk, reset (synchronous, active-high), bus (slave modport of
//        shift_add_multiplier_if: start/a/b in, ready/done/product out).
// Optional feature macro: SHIFT_ADD_MUL_EARLY_EXIT_EN
module shift_add_multiplier #(
    parameter int WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    shift_add_multiplier_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   product_q;

    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     mplier_nxt;
    logic                 last;

    // Next-state and decoded outputs
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        mplier_nxt = mplier >> 1;
        last       = 1'b0;

        if (mplier[0]) begin
            acc_nxt = acc + mcand;
        end

`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
        // Once no multiplier bits remain, further iterations add nothing.
        last = (count == CW'(WIDTH - 1)) || (mplier_nxt == '0);
`else
        last = (count == CW'(WIDTH - 1));
`endif

        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
            product_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= {{WIDTH{1'b0}}, bus.a};
                        mplier <= bus.b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier_nxt;
                    count  <= count + 1'b1;
                    // Publish the accumulator including this iteration's add.
                    if (last) begin
                        product_q <= acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // ready and done decode from distinct states, so they can never overlap.
    assign bus.ready   = (state == IDLE);
    assign bus.done    = (state == DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized self-checking bench for shift_add_multiplier against an
// arithmetic reference (product = a*b, latency from the bit length of b).
module tb_shift_add_multiplier;
    localparam int W = 5;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    shift_add_multiplier_if #(.WIDTH(W)) mif ();

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference latency: number of edges from acceptance to done.
    function automatic int ref_lat(input int b);
`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
        int n;
        n = 0;
        while (b != 0) begin
            n++;
            b = b / 2;
        end
        return (n < 1) ? 1 : n;
`else
        return W;
`endif
    endfunction

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Waits for done after acceptance; returns edges taken (or -1 on timeout).
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 64; k++) begin
            edge1();
            if (mif.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) chk("timeout_done", 0, 1);
    endtask

    task automatic do_mul(input string tag, input int a, input int b);
        int lat;
        int guard;
        guard = 0;
        while (mif.ready !== 1'b1 && guard < 64) begin
            edge1();
            guard++;
        end
        chk({tag, "_ready_pre"}, mif.ready, 1);
        mif.start = 1'b1;
        mif.a     = W'(a);
        mif.b     = W'(b);
        edge1();                       // edge 0: acceptance
        mif.start = 1'b0;
        mif.a     = W'($urandom);      // must not disturb the product in flight
        mif.b     = W'($urandom);
        chk({tag, "_busy"}, mif.ready, 0);
        wait_done(lat);
        chk({tag, "_lat"}, lat, ref_lat(b));
        chk({tag, "_prod"}, mif.product, a * b);
        chk({tag, "_rdy_in_done"}, mif.ready, 0);
        edge1();
        chk({tag, "_done_pulse"}, mif.done, 0);
        chk({tag, "_ready_post"}, mif.ready, 1);
        chk({tag, "_prod_hold"}, mif.product, a * b);
    endtask

    initial begin
        int lat;
        int ra;
        int rb;
        n_chk     = 0;
        n_err     = 0;
        reset     = 1'b1;
        mif.start = 1'b0;
        mif.a     = '0;
        mif.b     = '0;
        edge1();
        edge1();
        reset = 1'b0;
        chk("rst_ready", mif.ready, 1);
        chk("rst_done", mif.done, 0);
        chk("rst_prod", mif.product, 0);

        do_mul("basic", 5, 3);
        do_mul("full", 31, 31);
        do_mul("a0", 0, 17);
        do_mul("b0", 31, 0);
        do_mul("b16", 1, 16);

        // Busy: pulse 2x2, then hold start with 7x7 through RUN and DONE.
        mif.start = 1'b1;
        mif.a     = W'(2);
        mif.b     = W'(2);
        edge1();
        mif.a = W'(7);
        mif.b = W'(7);
        wait_done(lat);
        chk("busy_lat1", lat, ref_lat(2));
        chk("busy_prod1", mif.product, 4);
        edge1();
        chk("busy_done_once", mif.done, 0);
        chk("busy_ready", mif.ready, 1);
        edge1();                       // held request accepted here
        mif.start = 1'b0;
        chk("busy_accepted", mif.ready, 0);
        wait_done(lat);
        chk("busy_lat2", lat, ref_lat(7));
        chk("busy_prod2", mif.product, 49);
        edge1();

        // Reset mid-operation, sampled at edge 3.
        mif.start = 1'b1;
        mif.a     = W'(9);
        mif.b     = W'(9);
        edge1();
        mif.start = 1'b0;
        edge1();
        chk("abort_no_done1", mif.done, 0);
        edge1();
        chk("abort_no_done2", mif.done, 0);
        reset = 1'b1;
        edge1();
        reset = 1'b0;
        chk("abort_done", mif.done, 0);
        chk("abort_prod", mif.product, 0);
        chk("abort_ready", mif.ready, 1);
        for (int k = 0; k < 6; k++) begin
            edge1();
            chk("abort_quiet", mif.done, 0);
        end
        do_mul("post_abort", 3, 4);

        for (int i = 0; i < 40; i++) begin
            ra = int'($urandom_range(0, 31));
            rb = int'($urandom_range(0, 31));
            do_mul("rand", ra, rb);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) edge1();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
